// File: rtl/pipeline_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_ctrl_pkg
//  Description : Shared types and constants for the pipeline hazard and
//                sequencing controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipeline_ctrl_pkg;

    // Default width of the saturating stall-cycle counter
    localparam int PCTRL_CNT_W = 16;

    // Default register index width
    localparam int PCTRL_REG_W = 5;

    // Controller FSM states
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        HALT  = 2'd2
    } pctrl_state_t;

endpackage : pipeline_ctrl_pkg
`default_nettype wire

// File: rtl/pipeline_ctrl_hazard_detect.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_detect
//  Description : Load-use detector. Flags a load in EX whose destination is
//                a source of the instruction in ID. Register 0 never hazards.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect #(
    parameter int REG_W = 5
) (
    input  logic             memread_ID_EX,
    input  logic [REG_W-1:0] Rt_ID_EX,
    input  logic [REG_W-1:0] Rs_IF_ID,
    input  logic [REG_W-1:0] Rt_IF_ID,
    output logic             lu
);

    // Destination match against either ID source, ignoring register 0
    always_comb begin
        lu = memread_ID_EX
           & (Rt_ID_EX != '0)
           & ((Rt_ID_EX == Rs_IF_ID) | (Rt_ID_EX == Rt_IF_ID));
    end

endmodule : hazard_detect
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_ctrl
//  Description : Hazard and sequencing controller for the five-stage
//                pipeline. Drives the pipeline register enables/flushes and
//                the PC enable, resolves memory wait, branch, load-use and
//                fetch-miss conditions by fixed priority, latches halt and
//                counts stall cycles (saturating).
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_W = PCTRL_CNT_W,
    parameter int REG_W = PCTRL_REG_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             dmemREN_EX_MEM,
    input  logic             dmemWEN_EX_MEM,
    input  logic             halt_EX_MEM,
    input  logic             pc_src_EX_MEM,
    input  logic             memread_ID_EX,
    input  logic [REG_W-1:0] Rt_ID_EX,
    input  logic [REG_W-1:0] Rs_IF_ID,
    input  logic [REG_W-1:0] Rt_IF_ID,
    output logic             pc_enable,
    output logic             enable_IF_ID,
    output logic             enable_ID_EX,
    output logic             enable_EX_MEM,
    output logic             enable_MEM_WB,
    output logic             flush_IF_ID,
    output logic             flush_ID_EX,
    output logic             flush_EX_MEM,
    output logic             halt,
    output logic [CNT_W-1:0] stall_count
);

    pctrl_state_t     state_q, state_d;
    logic             halt_q, halt_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic             mreq;
    logic             lu;
    logic             resolve;

    hazard_detect #(
        .REG_W (REG_W)
    ) u_hazard_detect (
        .memread_ID_EX (memread_ID_EX),
        .Rt_ID_EX      (Rt_ID_EX),
        .Rs_IF_ID      (Rs_IF_ID),
        .Rt_IF_ID      (Rt_IF_ID),
        .lu            (lu)
    );

    assign mreq = dmemREN_EX_MEM | dmemWEN_EX_MEM;

    // Next state and zero-latency enable/flush decode; everything idles in reset
    always_comb begin
        state_d       = state_q;
        halt_d        = halt_q;
        resolve       = 1'b0;
        pc_enable     = 1'b0;
        enable_IF_ID  = 1'b0;
        enable_ID_EX  = 1'b0;
        enable_EX_MEM = 1'b0;
        enable_MEM_WB = 1'b0;
        flush_IF_ID   = 1'b0;
        flush_ID_EX   = 1'b0;
        flush_EX_MEM  = 1'b0;

        if (!RST) begin
            case (state_q)
                RUN: begin
                    // An access completing this very cycle is not a stall
                    if (mreq && !dhit) begin
                        state_d = DWAIT;
                    end else begin
                        resolve = 1'b1;
                    end
                end
                DWAIT: begin
                    if (dhit) begin
                        state_d = RUN;
                        resolve = 1'b1;
                    end
                end
                default: ;  // HALT: frozen until reset
            endcase

            if (resolve) begin
                if (halt_EX_MEM) begin
                    // Let the halt retire through writeback, freeze the rest
                    enable_MEM_WB = 1'b1;
                    state_d       = HALT;
                    halt_d        = 1'b1;
                end else if (pc_src_EX_MEM) begin
                    // Branch wins over load-use and fetch miss; the PC takes
                    // the target regardless of ihit and the wrong-path
                    // instructions (including any in-flight fetch) are squashed
                    pc_enable     = 1'b1;
                    enable_IF_ID  = 1'b1;
                    enable_ID_EX  = 1'b1;
                    enable_EX_MEM = 1'b1;
                    enable_MEM_WB = 1'b1;
                    flush_IF_ID   = 1'b1;
                    flush_ID_EX   = 1'b1;
                    flush_EX_MEM  = 1'b1;
                end else if (lu) begin
                    // Hold PC and IF/ID, inject a bubble into EX
                    enable_ID_EX  = 1'b1;
                    flush_ID_EX   = 1'b1;
                    enable_EX_MEM = 1'b1;
                    enable_MEM_WB = 1'b1;
                end else if (!ihit) begin
                    // Fetch miss: hold PC, bubble into ID, drain downstream
                    enable_IF_ID  = 1'b1;
                    flush_IF_ID   = 1'b1;
                    enable_ID_EX  = 1'b1;
                    enable_EX_MEM = 1'b1;
                    enable_MEM_WB = 1'b1;
                end else begin
                    pc_enable     = 1'b1;
                    enable_IF_ID  = 1'b1;
                    enable_ID_EX  = 1'b1;
                    enable_EX_MEM = 1'b1;
                    enable_MEM_WB = 1'b1;
                end
            end
        end
    end

    // Saturating stall counter: counts PC-held cycles outside HALT
    always_comb begin
        stall_count_d = stall_count_q;
        if (!pc_enable && (state_q != HALT) && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    // State, halt flag and counter registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= RUN;
            halt_q        <= 1'b0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            halt_q        <= halt_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign halt        = halt_q;
    assign stall_count = stall_count_q;

endmodule : pipeline_ctrl
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_ctrl
//  Description : Directed self-checking bench for pipeline_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

    // Packed output word: {pc, enIF, enID, enEX, enMEM, flIF, flID, flEX}
    localparam logic [7:0] c_FREEZE = 8'b0_0000_000;
    localparam logic [7:0] c_NORMAL = 8'b1_1111_000;
    localparam logic [7:0] c_LU     = 8'b0_0111_010;
    localparam logic [7:0] c_IMISS  = 8'b0_1111_100;
    localparam logic [7:0] c_BRANCH = 8'b1_1111_111;
    localparam logic [7:0] c_HALT1  = 8'b0_0001_000;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ihit, dhit, dmemREN_EX_MEM, dmemWEN_EX_MEM;
    logic        halt_EX_MEM, pc_src_EX_MEM, memread_ID_EX;
    logic [4:0]  Rt_ID_EX, Rs_IF_ID, Rt_IF_ID;
    logic        pc_enable, enable_IF_ID, enable_ID_EX, enable_EX_MEM, enable_MEM_WB;
    logic        flush_IF_ID, flush_ID_EX, flush_EX_MEM, halt;
    logic [15:0] stall_count;

    int r_checks = 0;
    int r_errors = 0;

    always #5 CLK = ~CLK;

    pipeline_ctrl #(
        .CNT_W (16),
        .REG_W (5)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .ihit           (ihit),
        .dhit           (dhit),
        .dmemREN_EX_MEM (dmemREN_EX_MEM),
        .dmemWEN_EX_MEM (dmemWEN_EX_MEM),
        .halt_EX_MEM    (halt_EX_MEM),
        .pc_src_EX_MEM  (pc_src_EX_MEM),
        .memread_ID_EX  (memread_ID_EX),
        .Rt_ID_EX       (Rt_ID_EX),
        .Rs_IF_ID       (Rs_IF_ID),
        .Rt_IF_ID       (Rt_IF_ID),
        .pc_enable      (pc_enable),
        .enable_IF_ID   (enable_IF_ID),
        .enable_ID_EX   (enable_ID_EX),
        .enable_EX_MEM  (enable_EX_MEM),
        .enable_MEM_WB  (enable_MEM_WB),
        .flush_IF_ID    (flush_IF_ID),
        .flush_ID_EX    (flush_ID_EX),
        .flush_EX_MEM   (flush_EX_MEM),
        .halt           (halt),
        .stall_count    (stall_count)
    );

    function automatic logic [7:0] outs();
        return {pc_enable, enable_IF_ID, enable_ID_EX, enable_EX_MEM, enable_MEM_WB,
                flush_IF_ID, flush_ID_EX, flush_EX_MEM};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        r_checks++;
        if (obs !== exp) begin
            r_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        ihit = 1'b1; dhit = 1'b0; dmemREN_EX_MEM = 1'b0; dmemWEN_EX_MEM = 1'b0;
        halt_EX_MEM = 1'b0; pc_src_EX_MEM = 1'b0; memread_ID_EX = 1'b0;
        Rt_ID_EX = '0; Rs_IF_ID = '0; Rt_IF_ID = '0;
    endtask

    initial begin
        RST = 1'b1;
        idle_inputs();
        #1;
        check("rst_outs", {24'd0, outs()}, {24'd0, c_FREEZE});
        tick();
        tick();
        check("rst_cnt", {16'd0, stall_count}, 32'd0);
        check("rst_halt", {31'd0, halt}, 32'd0);

        // Normal flow after reset
        RST = 1'b0;
        #1;
        check("run_outs", {24'd0, outs()}, {24'd0, c_NORMAL});
        tick();
        check("run_cnt", {16'd0, stall_count}, 32'd0);

        // Load waiting three cycles on the data memory
        dmemREN_EX_MEM = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("dwait_outs", {24'd0, outs()}, {24'd0, c_FREEZE});
            tick();
        end
        dhit = 1'b1;
        #1;
        check("dhit_outs", {24'd0, outs()}, {24'd0, c_NORMAL});
        tick();
        idle_inputs();
        check("dwait_cnt", {16'd0, stall_count}, 32'd3);

        // Store completing in the same cycle is not a stall
        dmemWEN_EX_MEM = 1'b1; dhit = 1'b1;
        #1;
        check("st_hit_outs", {24'd0, outs()}, {24'd0, c_NORMAL});
        tick();
        idle_inputs();
        check("st_hit_cnt", {16'd0, stall_count}, 32'd3);

        // Load-use on Rs, then on Rt, then against register 0
        memread_ID_EX = 1'b1; Rt_ID_EX = 5'd5; Rs_IF_ID = 5'd5;
        #1;
        check("lu_rs_outs", {24'd0, outs()}, {24'd0, c_LU});
        tick();
        Rs_IF_ID = 5'd3; Rt_IF_ID = 5'd5;
        #1;
        check("lu_rt_outs", {24'd0, outs()}, {24'd0, c_LU});
        tick();
        check("lu_cnt", {16'd0, stall_count}, 32'd5);
        Rt_ID_EX = 5'd0; Rs_IF_ID = 5'd0; Rt_IF_ID = 5'd0;
        #1;
        check("lu_r0_outs", {24'd0, outs()}, {24'd0, c_NORMAL});
        tick();
        idle_inputs();

        // Instruction miss
        ihit = 1'b0;
        #1;
        check("imiss_outs", {24'd0, outs()}, {24'd0, c_IMISS});
        tick();
        check("imiss_cnt", {16'd0, stall_count}, 32'd6);

        // Branch beats load-use and fetch miss
        pc_src_EX_MEM = 1'b1; memread_ID_EX = 1'b1; Rt_ID_EX = 5'd5; Rs_IF_ID = 5'd5;
        #1;
        check("br_lu_outs", {24'd0, outs()}, {24'd0, c_BRANCH});
        tick();
        idle_inputs();
        pc_src_EX_MEM = 1'b1;
        #1;
        check("br_hit_outs", {24'd0, outs()}, {24'd0, c_BRANCH});
        tick();
        check("br_cnt", {16'd0, stall_count}, 32'd6);

        // Data wait beats branch; branch resolves on the dhit cycle
        dmemREN_EX_MEM = 1'b1;
        #1;
        check("br_dw_outs", {24'd0, outs()}, {24'd0, c_FREEZE});
        tick();
        dhit = 1'b1;
        #1;
        check("br_dhit_outs", {24'd0, outs()}, {24'd0, c_BRANCH});
        tick();
        idle_inputs();
        check("br_dw_cnt", {16'd0, stall_count}, 32'd7);

        // Halt: writeback only on entry, then frozen and sticky
        halt_EX_MEM = 1'b1;
        #1;
        check("halt_entry_outs", {24'd0, outs()}, {24'd0, c_HALT1});
        tick();
        halt_EX_MEM = 1'b0; ihit = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("halt_outs", {24'd0, outs()}, {24'd0, c_FREEZE});
            check("halt_flag", {31'd0, halt}, 32'd1);
            check("halt_cnt", {16'd0, stall_count}, 32'd8);
            tick();
        end
        RST = 1'b1;
        tick();
        RST = 1'b0; ihit = 1'b1;
        #1;
        check("halt_clr_flag", {31'd0, halt}, 32'd0);
        check("halt_clr_cnt", {16'd0, stall_count}, 32'd0);
        check("halt_clr_outs", {24'd0, outs()}, {24'd0, c_NORMAL});
        tick();

        // Reset in the middle of a data wait: the late dhit is ignored
        dmemREN_EX_MEM = 1'b1;
        tick();
        RST = 1'b1; dhit = 1'b1;
        tick();
        RST = 1'b0;
        idle_inputs();
        #1;
        check("rst_dw_outs", {24'd0, outs()}, {24'd0, c_NORMAL});
        check("rst_dw_cnt", {16'd0, stall_count}, 32'd0);
        tick();

        // Counter saturation across 2^16+5 miss cycles
        ihit = 1'b0;
        repeat (65534) tick();
        check("sat_fffe", {16'd0, stall_count}, 32'h0000FFFE);
        tick();
        check("sat_ffff", {16'd0, stall_count}, 32'h0000FFFF);
        repeat (6) tick();
        check("sat_hold", {16'd0, stall_count}, 32'h0000FFFF);

        $display("CHECKS %0d ERRORS %0d", r_checks, r_errors);
        $finish;
    end

endmodule : tb_pipeline_ctrl
`default_nettype wire

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Hazard and sequencing controller for the five-stage pipeline. Drives the enable/flush pair of every pipeline register (IF_ID, ID_EX, EX_MEM, MEM_WB) and the PC enable. Resolves data-memory wait, taken branch/jump, load-use and instruction-miss conditions by fixed priority. Latches halt and keeps a saturating stall-cycle counter for performance reporting.

Parameters:
CNT_W, 16, width of stall-cycle counter
REG_W, 5, register index width (regbits_t)

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  synchronous reset, active-high
ihit  in  1  instruction fetch complete this cycle
dhit  in  1  data access complete this cycle
dmemREN_EX_MEM  in  1  load in MEM stage
dmemWEN_EX_MEM  in  1  store in MEM stage
halt_EX_MEM  in  1  halt instruction in MEM stage
pc_src_EX_MEM  in  1  taken branch/jump resolved in MEM stage
memread_ID_EX  in  1  load in EX stage
Rt_ID_EX  in  REG_W  load destination in EX stage
Rs_IF_ID, Rt_IF_ID  in  REG_W  source registers in ID stage
pc_enable  out  1  PC update
enable_IF_ID, enable_ID_EX, enable_EX_MEM, enable_MEM_WB  out  1 each  register load enables
flush_IF_ID, flush_ID_EX, flush_EX_MEM  out  1 each  load bubble (zero control) instead of data
halt  out  1  sticky halt to datapath/system
stall_count  out  CNT_W  stall cycles since reset

Behaviour:
- Clock CLK; reset synchronous, active-high, signal RST. RST=1 at a rising edge sets state=RUN, halt=0, stall_count=0. While RST is high, all enables and flushes are forced to 0.
- FSM states: RUN, DWAIT, HALT. The state register and counter are registered. Enables and flushes are combinational from state and inputs, giving zero-latency response to ihit/dhit.
- Define mreq = dmemREN_EX_MEM | dmemWEN_EX_MEM.
- Define lu = memread_ID_EX & (Rt_ID_EX != 0) & (Rt_ID_EX == Rs_IF_ID | Rt_ID_EX == Rt_IF_ID).
- RUN outputs, in strict priority order:
  1. mreq & !dhit: all enables 0, pc_enable 0 (freeze). Next state DWAIT.
  2. halt_EX_MEM: enable_MEM_WB 1, all other enables 0, pc_enable 0. Next state HALT; halt<=1.
  3. pc_src_EX_MEM & ihit: all enables 1, pc_enable 1, flush_IF_ID, flush_ID_EX and flush_EX_MEM all 1.
  4. pc_src_EX_MEM & !ihit: same as 3, but pc_enable 1 still loads the target. An in-flight fetch is discarded by flush_IF_ID.
  5. lu: pc_enable 0, enable_IF_ID 0, enable_ID_EX 1 with flush_ID_EX 1, enable_EX_MEM/MEM_WB 1.
  6. !ihit: pc_enable 0, enable_IF_ID 1 with flush_IF_ID 1, downstream enables 1.
  7. otherwise: all enables 1, pc_enable 1, no flush.
- A cycle where mreq & dhit both hold is not a stall; evaluation continues at rule 2.
- DWAIT: freeze all while !dhit. On dhit, evaluate RUN rules 2–7 in the same cycle and return to RUN. If halt_EX_MEM is set, go to HALT instead.
- HALT: all enables 0, pc_enable 0, halt=1. Only RST exits.
- A flush takes effect only when the matching enable is 1. Flush with enable 0 is illegal and must never be driven.
- stall_count increments by 1 in any non-reset cycle with pc_enable=0 and state != HALT. It saturates at all-ones, with no wrap.
- Reset mid-DWAIT or mid-HALT: the next cycle is RUN with counter 0. An outstanding dhit for the aborted access is ignored.

Decomposition:
- cpu_types_pkg: regbits_t, word_t (existing).
- New pipeline_ctrl_pkg: typedef enum logic [1:0] {RUN, DWAIT, HALT} pctrl_state_t; constant CNT_W.
- One sub-module: hazard_detect (combinational lu comparison). The FSM and counter stay in pipeline_ctrl.

Test Plan:
- RST=1 for 2 cycles, then release with ihit=1 and no hazards -> all enables 1, pc_enable 1, no flush, stall_count=0.
- dmemREN_EX_MEM=1, dhit=0 for 3 cycles, then 1 -> state DWAIT, all enables 0 for 3 cycles; on the dhit cycle all enables 1 and state RUN; stall_count=3.
- memread_ID_EX=1, Rt_ID_EX=5, Rs_IF_ID=5 -> pc_enable 0, enable_IF_ID 0, flush_ID_EX 1. Repeat with Rt_ID_EX=0 -> no stall.
- pc_src_EX_MEM=1 together with lu=1 and ihit=0 -> branch wins: pc_enable 1, flush_IF_ID/ID_EX/EX_MEM all 1.
- halt_EX_MEM=1 -> enable_MEM_WB 1 for one cycle, then all 0. halt stays 1 for 10 cycles, stall_count does not change, and RST clears it.
- Force 2^16+5 ihit=0 cycles -> stall_count holds 16'hFFFF.
